// File: rtl/ls74191_updown_counter.sv
// 74191-style synchronous presettable up/down binary counter with terminal-count outputs.
// Define LS74191_RCO_REG_EN to register rco_n instead of deriving it combinationally.
module ls74191_updown_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic [WIDTH-1:0] d,
    input  logic             cten_n,
    input  logic             down_up,
    output logic [WIDTH-1:0] q,
    output logic             max_min,
    output logic             rco_n
);

    logic [WIDTH-1:0] q_next;

    function automatic logic at_terminal(input logic [WIDTH-1:0] v, input logic dir);
        at_terminal = dir ? (v == '0) : (v == '1);
    endfunction

    always_comb begin
        q_next = q;
        if (!load_n) begin
            q_next = d;
        end else if (!cten_n) begin
            q_next = down_up ? q - WIDTH'(1) : q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign max_min = at_terminal(q, down_up);

`ifdef LS74191_RCO_REG_EN
    // Anticipates the post-edge value, assuming direction and enable stay put across the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rco_n <= 1'b1;
        end else begin
            rco_n <= ~(at_terminal(q_next, down_up) & ~cten_n);
        end
    end
`else
    assign rco_n = ~(max_min & ~cten_n);
`endif

endmodule

// File: tb/tb_ls74191_updown_counter.sv
// Self-checking bench: arithmetic reference model checked every cycle plus directed literal checks.
module tb_ls74191_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n, load_n, cten_n, down_up;
    logic [3:0] d, q;
    logic       max_min, rco_n;

    logic       c_load_n, c_cten_n, c_dir;
    logic [7:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_mm, lo_rco, hi_mm, hi_rco;

    int vectors = 0;
    int miscompares = 0;
    int m_q;
    int c_q;
    logic checking_en = 1'b0;

    ls74191_updown_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .d(d), .cten_n(cten_n),
        .down_up(down_up), .q(q), .max_min(max_min), .rco_n(rco_n)
    );

    ls74191_updown_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .rst_n(rst_n), .load_n(c_load_n), .d(c_d[3:0]), .cten_n(c_cten_n),
        .down_up(c_dir), .q(lo_q), .max_min(lo_mm), .rco_n(lo_rco)
    );

    ls74191_updown_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .rst_n(rst_n), .load_n(c_load_n), .d(c_d[7:4]), .cten_n(lo_rco),
        .down_up(c_dir), .q(hi_q), .max_min(hi_mm), .rco_n(hi_rco)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= 0;
            c_q <= 0;
        end else begin
            if (!load_n)      m_q <= int'(d);
            else if (!cten_n) m_q <= down_up ? (m_q + 15) % 16 : (m_q + 1) % 16;
            if (!c_load_n)      c_q <= int'(c_d);
            else if (!c_cten_n) c_q <= (c_q + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (checking_en) begin
            logic exp_mm;
            exp_mm = down_up ? (m_q == 0) : (m_q == 15);
            check("model_q", 16'(q), 16'(m_q));
            check("model_max_min", 16'(max_min), 16'(exp_mm));
            check("model_rco_n", 16'(rco_n), 16'(!(exp_mm && !cten_n)));
            check("model_casc_q", {8'h00, hi_q, lo_q}, 16'(c_q));
            check("model_casc_rco", 16'(hi_rco), 16'(!(c_q == 255 && !c_cten_n)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [3:0] v);
        load_n = 1'b0;
        d = v;
        step();
        load_n = 1'b1;
    endtask

    initial begin
        logic [3:0] inv_src;
        rst_n = 1'b1; load_n = 1'b1; cten_n = 1'b1; down_up = 1'b0; d = 4'h0;
        c_load_n = 1'b1; c_cten_n = 1'b1; c_dir = 1'b0; c_d = 8'h00;
        #2 rst_n = 1'b0;
        #1 checking_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Asynchronous reset mid-cycle
        load4(4'h9);
        check("load_9", 16'(q), 16'h9);
        #1 rst_n = 1'b0;
        #1;
        check("reset_q", 16'(q), 16'h0);
        check("reset_mm_up", 16'(max_min), 16'h0);
        check("reset_rco", 16'(rco_n), 16'h1);
        down_up = 1'b1;
        #1;
        check("reset_mm_down", 16'(max_min), 16'h1);
        down_up = 1'b0;
        rst_n = 1'b1;
        step();

        // Load of inverted operand beats count
        inv_src = 4'b1010;
        d = ~inv_src;
        load_n = 1'b0; cten_n = 1'b0;
        step();
        check("load_beats_count", 16'(q), 16'h5);
        load_n = 1'b1;
        step();
        check("count_after_load", 16'(q), 16'h6);
        cten_n = 1'b1;

        // Up wrap
        load4(4'hE);
        cten_n = 1'b0;
        step();
        check("up_F", 16'(q), 16'hF);
        check("up_F_mm", 16'(max_min), 16'h1);
        check("up_F_rco", 16'(rco_n), 16'h0);
        step();
        check("up_wrap_0", 16'(q), 16'h0);
        check("up_0_rco", 16'(rco_n), 16'h1);
        cten_n = 1'b1;

        // Down wrap
        load4(4'h1);
        down_up = 1'b1; cten_n = 1'b0;
        step();
        check("down_0", 16'(q), 16'h0);
        check("down_0_mm", 16'(max_min), 16'h1);
        check("down_0_rco", 16'(rco_n), 16'h0);
        cten_n = 1'b1;
        #1;
        check("down_0_rco_disabled", 16'(rco_n), 16'h1);
        cten_n = 1'b0;
        step();
        check("down_wrap_F", 16'(q), 16'hF);
        check("down_F_mm", 16'(max_min), 16'h0);
        cten_n = 1'b1; down_up = 1'b0;

        // Hold and direction toggle
        load4(4'h3);
        repeat (5) step();
        check("hold_3", 16'(q), 16'h3);
        down_up = 1'b1;
        #1;
        check("hold_dir_q", 16'(q), 16'h3);
        check("hold_dir_mm", 16'(max_min), 16'h0);
        down_up = 1'b0;
        step();

        // Reset abandons a count in progress
        cten_n = 1'b0;
        step();
        check("count_4", 16'(q), 16'h4);
        #1 rst_n = 1'b0;
        #1;
        check("reset_mid_count", 16'(q), 16'h0);
        rst_n = 1'b1;
        cten_n = 1'b1;
        step();

        // Cascade of two nibbles
        c_d = 8'h0E; c_load_n = 1'b0;
        step();
        c_load_n = 1'b1; c_cten_n = 1'b0;
        step();
        check("casc_0F", {8'h00, hi_q, lo_q}, 16'h000F);
        check("casc_lo_rco", 16'(lo_rco), 16'h0);
        step();
        check("casc_10", {8'h00, hi_q, lo_q}, 16'h0010);
        step();
        check("casc_11", {8'h00, hi_q, lo_q}, 16'h0011);
        c_cten_n = 1'b1;
        c_d = 8'hFF; c_load_n = 1'b0;
        step();
        c_load_n = 1'b1; c_cten_n = 1'b0;
        #1;
        check("casc_FF_rco", 16'(hi_rco), 16'h0);
        step();
        check("casc_wrap_00", {8'h00, hi_q, lo_q}, 16'h0000);
        c_cten_n = 1'b1;
        step();

        checking_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
